// File: rtl/mux_alu_src.sv
// ALU B-operand source select for the execute stage.
// The combinational path picks the forwarded register value, the extended
// immediate or PC+4 and presents it to the ALU with no latency. A registered
// copy of the operand and of the select code is kept for downstream use and
// debug, and a sticky flag records any use of the reserved select code.
module mux_alu_src #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       AluSrc,
    input  logic [WIDTH-1:0] DE_RD2,
    input  logic [WIDTH-1:0] DE_Ext,
    input  logic [WIDTH-1:0] DE_Pc4,
    input  logic [1:0]       FwdB,
    input  logic [WIDTH-1:0] EM_Alu,
    input  logic [WIDTH-1:0] MW_Wd,
    output logic [WIDTH-1:0] AluB,
    output logic [WIDTH-1:0] AluB_q,
    output logic [1:0]       Sel_q,
    output logic             Bad_sel
);

    // AluSrc encodings
    localparam logic [1:0] SRC_REG = 2'd0;
    localparam logic [1:0] SRC_EXT = 2'd1;
    localparam logic [1:0] SRC_PC4 = 2'd2;
    localparam logic [1:0] SRC_RSV = 2'd3;

    // FwdB encodings (code 3 falls back to the register file value)
    localparam logic [1:0] FWD_EM = 2'd1;
    localparam logic [1:0] FWD_MW = 2'd2;

    logic [WIDTH-1:0] w_fwd_rd2;
    logic [WIDTH-1:0] w_alub;
    logic             w_bad_now;

    logic [WIDTH-1:0] r_alub_q;
    logic [1:0]       r_sel_q;
    logic             r_bad_sel;

    // Forwarding mux: resolve the rt operand against in-flight results
    always_comb begin
        w_fwd_rd2 = DE_RD2;
        case (FwdB)
            FWD_EM:  w_fwd_rd2 = EM_Alu;
            FWD_MW:  w_fwd_rd2 = MW_Wd;
            default: w_fwd_rd2 = DE_RD2;
        endcase
    end

    // Source mux: pick the ALU B operand; reserved code drives zero
    always_comb begin
        w_alub = '0;
        case (AluSrc)
            SRC_REG: w_alub = w_fwd_rd2;
            SRC_EXT: w_alub = DE_Ext;
            SRC_PC4: w_alub = DE_Pc4;
            SRC_RSV: w_alub = '0;
            default: w_alub = '0;
        endcase
    end

    assign w_bad_now = (AluSrc == SRC_RSV);

    // Pipeline register: reset wins, otherwise load on enable and hold on stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alub_q  <= '0;
            r_sel_q   <= SRC_REG;
            r_bad_sel <= 1'b0;
        end else if (en) begin
            r_alub_q <= w_alub;
            r_sel_q  <= AluSrc;
            if (w_bad_now) begin
                r_bad_sel <= 1'b1;
            end
        end
    end

    assign AluB    = w_alub;
    assign AluB_q  = r_alub_q;
    assign Sel_q   = r_sel_q;
    assign Bad_sel = r_bad_sel;

endmodule

// File: tb/tb_mux_alu_src.sv
// Testbench for mux_alu_src: directed scenarios plus randomized traffic,
// checked against a table-lookup reference model and a registered-value
// expectation queue.
module tb_mux_alu_src;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         en;
    logic [1:0]   AluSrc;
    logic [W-1:0] DE_RD2;
    logic [W-1:0] DE_Ext;
    logic [W-1:0] DE_Pc4;
    logic [1:0]   FwdB;
    logic [W-1:0] EM_Alu;
    logic [W-1:0] MW_Wd;
    logic [W-1:0] AluB;
    logic [W-1:0] AluB_q;
    logic [1:0]   Sel_q;
    logic         Bad_sel;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for the registered outputs
    logic [W-1:0] m_q;
    logic [1:0]   m_sel;
    logic         m_bad;
    logic [W-1:0] exp_q[$];

    mux_alu_src #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .AluSrc(AluSrc),
        .DE_RD2(DE_RD2), .DE_Ext(DE_Ext), .DE_Pc4(DE_Pc4), .FwdB(FwdB),
        .EM_Alu(EM_Alu), .MW_Wd(MW_Wd),
        .AluB(AluB), .AluB_q(AluB_q), .Sel_q(Sel_q), .Bad_sel(Bad_sel)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: operand tables indexed directly by the select codes
    function automatic logic [W-1:0] ref_alub();
        logic [W-1:0] fwd_tbl[4];
        logic [W-1:0] src_tbl[4];
        fwd_tbl = '{DE_RD2, EM_Alu, MW_Wd, DE_RD2};
        src_tbl = '{fwd_tbl[FwdB], DE_Ext, DE_Pc4, '0};
        return src_tbl[AluSrc];
    endfunction

    // Driver: one clock edge with model update, outputs sampled 1ns after
    task automatic tick();
        logic [W-1:0] nq;
        logic [1:0]   nsel;
        logic         nbad;
        nq = m_q; nsel = m_sel; nbad = m_bad;
        if (reset) begin
            nq = '0; nsel = 2'd0; nbad = 1'b0;
        end else if (en) begin
            nq = ref_alub(); nsel = AluSrc; nbad = m_bad | (AluSrc == 2'd3);
        end
        @(posedge clk);
        #1;
        m_q = nq; m_sel = nsel; m_bad = nbad;
    endtask

    task automatic randomize_data();
        DE_RD2 = $urandom(); DE_Ext = $urandom(); DE_Pc4 = $urandom();
        EM_Alu = $urandom(); MW_Wd = $urandom();
        FwdB   = 2'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; AluSrc = 2'd1;
        randomize_data();
        tick();
        tick();
        n_checks++;
        if (AluB_q !== '0) begin
            n_errors++; $display("FAIL reset_alub_q got %h exp 0", AluB_q);
        end
        n_checks++;
        if (Sel_q !== 2'd0) begin
            n_errors++; $display("FAIL reset_sel_q got %0d exp 0", Sel_q);
        end
        n_checks++;
        if (Bad_sel !== 1'b0) begin
            n_errors++; $display("FAIL reset_bad_sel got %b exp 0", Bad_sel);
        end
        // The operand stays combinational while reset is held
        DE_Ext = 32'hCAFE_0001;
        #1;
        n_checks++;
        if (AluB !== 32'hCAFE_0001) begin
            n_errors++; $display("FAIL reset_comb got %h exp cafe0001", AluB);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        en = 1'b1; AluSrc = 2'd0; FwdB = 2'd0; DE_RD2 = 32'h1234_5678;
        #1;
        n_checks++;
        if (AluB !== 32'h1234_5678) begin
            n_errors++; $display("FAIL reg_path got %h exp 12345678", AluB);
        end
        tick();
        n_checks++;
        if (AluB_q !== 32'h1234_5678 || Sel_q !== 2'd0) begin
            n_errors++; $display("FAIL reg_load got %h/%0d exp 12345678/0", AluB_q, Sel_q);
        end
        AluSrc = 2'd1; DE_Ext = 32'hFFFF_8000; #1;
        n_checks++;
        if (AluB !== 32'hFFFF_8000) begin
            n_errors++; $display("FAIL ext_path got %h exp ffff8000", AluB);
        end
        AluSrc = 2'd2; DE_Pc4 = 32'h0000_3004; #1;
        n_checks++;
        if (AluB !== 32'h0000_3004) begin
            n_errors++; $display("FAIL pc4_path got %h exp 00003004", AluB);
        end
        AluSrc = 2'd0; FwdB = 2'd1; EM_Alu = 32'hA5A5_A5A5; #1;
        n_checks++;
        if (AluB !== 32'hA5A5_A5A5) begin
            n_errors++; $display("FAIL fwd_em got %h exp a5a5a5a5", AluB);
        end
        FwdB = 2'd2; MW_Wd = 32'h0000_BEEF; #1;
        n_checks++;
        if (AluB !== 32'h0000_BEEF) begin
            n_errors++; $display("FAIL fwd_mw got %h exp 0000beef", AluB);
        end
        FwdB = 2'd3; #1;
        n_checks++;
        if (AluB !== 32'h1234_5678) begin
            n_errors++; $display("FAIL fwd_3 got %h exp 12345678", AluB);
        end
        // Immediate path ignores every forward select
        AluSrc = 2'd1;
        for (int f = 0; f < 4; f++) begin
            FwdB = 2'(f); #1;
            n_checks++;
            if (AluB !== 32'hFFFF_8000) begin
                n_errors++; $display("FAIL ext_ignores_fwd fwd=%0d got %h exp ffff8000", f, AluB);
            end
        end
        tick();
        n_checks++;
        if (Sel_q !== 2'd1 || AluB_q !== 32'hFFFF_8000) begin
            n_errors++; $display("FAIL ext_load got %h/%0d exp ffff8000/1", AluB_q, Sel_q);
        end
    endtask

    task automatic test_bad_sel();
        en = 1'b1; AluSrc = 2'd3; randomize_data(); #1;
        n_checks++;
        if (AluB !== '0) begin
            n_errors++; $display("FAIL rsv_comb got %h exp 0", AluB);
        end
        tick();
        n_checks++;
        if (AluB_q !== '0 || Sel_q !== 2'd3 || Bad_sel !== 1'b1) begin
            n_errors++; $display("FAIL rsv_edge got q=%h sel=%0d bad=%b exp 0/3/1", AluB_q, Sel_q, Bad_sel);
        end
        AluSrc = 2'd0;
        for (int i = 0; i < 3; i++) begin
            randomize_data();
            tick();
            n_checks++;
            if (Bad_sel !== 1'b1) begin
                n_errors++; $display("FAIL bad_sticky cyc=%0d got %b exp 1", i, Bad_sel);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] held_q;
        logic [1:0]   held_sel;
        en = 1'b1; AluSrc = 2'd2; randomize_data();
        tick();
        held_q = m_q; held_sel = m_sel;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            AluSrc = 2'($urandom_range(0, 2)); randomize_data(); #1;
            n_checks++;
            if (AluB !== ref_alub()) begin
                n_errors++; $display("FAIL stall_comb cyc=%0d got %h exp %h", i, AluB, ref_alub());
            end
            tick();
            n_checks++;
            if (AluB_q !== held_q || Sel_q !== held_sel) begin
                n_errors++; $display("FAIL stall_hold cyc=%0d got %h/%0d exp %h/%0d", i, AluB_q, Sel_q, held_q, held_sel);
            end
        end
        // Reserved code during a stall must not set the flag
        reset = 1'b1; tick(); reset = 1'b0;
        AluSrc = 2'd3; tick();
        n_checks++;
        if (Bad_sel !== 1'b0 || Sel_q !== 2'd0) begin
            n_errors++; $display("FAIL stall_rsv got bad=%b sel=%0d exp 0/0", Bad_sel, Sel_q);
        end
        en = 1'b1; AluSrc = 2'd1; randomize_data(); tick();
        n_checks++;
        if (AluB_q !== DE_Ext || Sel_q !== 2'd1) begin
            n_errors++; $display("FAIL resume_load got %h/%0d exp %h/1", AluB_q, Sel_q, DE_Ext);
        end
    endtask

    task automatic test_reset_priority();
        en = 1'b1; AluSrc = 2'd3; randomize_data(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++;
        if (AluB_q !== '0 || Sel_q !== 2'd0 || Bad_sel !== 1'b0) begin
            n_errors++; $display("FAIL reset_prio got q=%h sel=%0d bad=%b exp 0/0/0", AluB_q, Sel_q, Bad_sel);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        for (int i = 0; i < 300; i++) begin
            reset  = ($urandom_range(0, 39) == 0);
            en     = ($urandom_range(0, 3) != 0);
            AluSrc = 2'($urandom_range(0, 3));
            randomize_data(); #1;
            n_checks++;
            if (AluB !== ref_alub()) begin
                n_errors++; $display("FAIL rand_comb cyc=%0d got %h exp %h", i, AluB, ref_alub());
            end
            tick();
            exp_q.push_back(m_q);
            e = exp_q.pop_front();
            n_checks++;
            if (AluB_q !== e || Sel_q !== m_sel || Bad_sel !== m_bad) begin
                n_errors++;
                $display("FAIL rand_reg cyc=%0d got %h/%0d/%b exp %h/%0d/%b", i, AluB_q, Sel_q, Bad_sel, e, m_sel, m_bad);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_q = '0; m_sel = 2'd0; m_bad = 1'b0;
        reset = 1'b1; en = 1'b0; AluSrc = 2'd0; FwdB = 2'd0;
        DE_RD2 = '0; DE_Ext = '0; DE_Pc4 = '0; EM_Alu = '0; MW_Wd = '0;
        test_reset();
        test_directed();
        test_bad_sel();
        test_stall();
        test_reset_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
